// File: rtl/miriscv_lsu_ctrl.sv
// miriscv load-store unit controller: core request -> word-aligned data bus.
// Define MIRISCV_LSU_SPLIT_MISALIGNED_EN to split misaligned accesses into two beats.
module miriscv_lsu_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [2:0]        lsu_size_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [31:0]       lsu_data_i,
    output logic [31:0]       lsu_data_o,
    output logic              lsu_stall_req_o,
    output logic              lsu_err_o,
    output logic              data_req_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [31:0]       data_wdata_o,
    input  logic [31:0]       data_rdata_i,
    input  logic              data_rvalid_i
);

    typedef enum logic [2:0] {
        IDLE, REQ, REQ2, DONE, ERR
    } state_t;

`ifdef MIRISCV_LSU_SPLIT_MISALIGNED_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TLAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t state, state_n;

    logic [CW-1:0]     cnt;
    logic              we_q;
    logic [2:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wd_q;
    logic [31:0]       lo, hi;

    function automatic logic [3:0] mask_of(input logic [1:0] s);
        case (s)
            2'b00:   mask_of = 4'b0001;
            2'b01:   mask_of = 4'b0011;
            default: mask_of = 4'b1111;
        endcase
    endfunction

    logic [3:0] in_m;
    logic       misal, illegal;

    always_comb begin
        in_m  = mask_of(lsu_size_i[1:0]);
        misal = ((lsu_size_i[1:0] == 2'b01) && lsu_addr_i[0]) ||
                ((lsu_size_i[1:0] == 2'b10) && (lsu_addr_i[1:0] != 2'b00));
        illegal = (lsu_size_i == 3'b011) ||
                  (lsu_size_i[2:1] == 2'b11) ||
                  (lsu_we_i && lsu_size_i[2]) ||
                  (!SPLIT && misal);
    end

    logic [1:0]        off;
    logic [7:0]        wide_be;
    logic [63:0]       wide_wd;
    logic [ADDR_W-1:0] word;
    logic              need2, timeout;
    logic [31:0]       sh;
    logic              sgn;
    logic [31:0]       ext;

    always_comb begin
        off     = addr_q[1:0];
        wide_be = {4'b0000, mask_of(size_q[1:0])} << off;
        wide_wd = {32'b0, wd_q} << {off, 3'b000};
        word    = {addr_q[ADDR_W-1:2], 2'b00};
        need2   = SPLIT && (wide_be[7:4] != 4'b0000);
        timeout = (TIMEOUT_CYCLES > 0) && (cnt == TLAST);
        sh      = 32'({hi, lo} >> {off, 3'b000});
        sgn     = ~size_q[2];
        case (size_q[1:0])
            2'b00:   ext = {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   ext = {{16{sgn & sh[15]}}, sh[15:0]};
            default: ext = sh;
        endcase
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (lsu_req_i) state_n = illegal ? ERR : REQ;
            REQ: begin
                if (data_rvalid_i) state_n = need2 ? REQ2 : DONE;
                else if (timeout)  state_n = ERR;
            end
            REQ2: begin
                if (data_rvalid_i) state_n = DONE;
                else if (timeout)  state_n = ERR;
            end
            DONE:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= IDLE;
            cnt    <= '0;
            we_q   <= 1'b0;
            size_q <= 3'b000;
            addr_q <= '0;
            wd_q   <= 32'b0;
            lo     <= 32'b0;
            hi     <= 32'b0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                cnt <= '0;
                if (lsu_req_i) begin
                    we_q   <= lsu_we_i;
                    size_q <= lsu_size_i;
                    addr_q <= lsu_addr_i;
                    wd_q   <= lsu_data_i &
                              {{8{in_m[3]}}, {8{in_m[2]}},
                               {8{in_m[1]}}, {8{in_m[0]}}};
                end
            end else if (state == REQ || state == REQ2) begin
                if (data_rvalid_i) begin
                    cnt <= '0;
                    if (state == REQ) lo <= data_rdata_i;
                    else              hi <= data_rdata_i;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        data_req_o   = 1'b0;
        data_we_o    = 1'b0;
        data_be_o    = 4'b0000;
        data_addr_o  = '0;
        data_wdata_o = 32'b0;
        lsu_data_o   = 32'b0;
        lsu_err_o    = (state == ERR);
        lsu_stall_req_o = lsu_req_i && !(state == DONE || state == ERR);
        if (state == REQ) begin
            data_req_o   = 1'b1;
            data_we_o    = we_q;
            data_be_o    = wide_be[3:0];
            data_addr_o  = word;
            data_wdata_o = wide_wd[31:0];
        end else if (state == REQ2) begin
            data_req_o   = 1'b1;
            data_we_o    = we_q;
            data_be_o    = wide_be[7:4];
            data_addr_o  = word + ADDR_W'(4);
            data_wdata_o = wide_wd[63:32];
        end
        if (state == DONE) lsu_data_o = ext;
    end

endmodule

// File: tb/tb_miriscv_lsu_ctrl.sv
// Directed bench for miriscv_lsu_ctrl with TIMEOUT_CYCLES=4.
// Split-misaligned scenarios follow MIRISCV_LSU_SPLIT_MISALIGNED_EN.
module tb_miriscv_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  size = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wd = 32'h0;
    logic [31:0] ldata;
    logic        stall, err;
    logic        dreq, dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr, dwdata;
    logic [31:0] rdata = 32'h0;
    logic        rvalid = 1'b0;

    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    miriscv_lsu_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .lsu_req_i(req), .lsu_we_i(we), .lsu_size_i(size),
        .lsu_addr_i(addr), .lsu_data_i(wd),
        .lsu_data_o(ldata), .lsu_stall_req_o(stall), .lsu_err_o(err),
        .data_req_o(dreq), .data_we_o(dwe), .data_be_o(dbe),
        .data_addr_o(daddr), .data_wdata_o(dwdata),
        .data_rdata_i(rdata), .data_rvalid_i(rvalid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic w, input logic [2:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = w; size = s; addr = a; wd = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ldata, stall, err, dreq, dwe, dbe, daddr, dwdata} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got=%h/%b/%b/%b/%b/%h/%h/%h exp=all zero",
                     ldata, stall, err, dreq, dwe, dbe, daddr, dwdata);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic run_load(input logic [2:0] s, input logic [31:0] a,
                            input logic [31:0] rd, input logic [31:0] ea,
                            input logic [3:0] ebe, input logic [31:0] ed,
                            input string nm);
        start(1'b0, s, a, 32'h0);
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || dreq !== 1'b0) begin
            fails++;
            $display("FAIL %s_c0 got stall=%b req=%b exp stall=1 req=0", nm, stall, dreq);
        end
        step();
        rvalid = 1'b1; rdata = rd;
        @(negedge clk);
        checks++;
        if (dreq !== 1'b1 || dwe !== 1'b0 || stall !== 1'b1) begin
            fails++;
            $display("FAIL %s_c1 got req=%b we=%b stall=%b exp 1/0/1", nm, dreq, dwe, stall);
        end
        checks++;
        if (daddr !== ea || dbe !== ebe) begin
            fails++;
            $display("FAIL %s_bus got addr=%h be=%b exp addr=%h be=%b", nm, daddr, dbe, ea, ebe);
        end
        step();
        rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (ldata !== ed || stall !== 1'b0 || dreq !== 1'b0) begin
            fails++;
            $display("FAIL %s_done got data=%h stall=%b req=%b exp data=%h stall=0 req=0",
                     nm, ldata, stall, dreq, ed);
        end
        step();
        req = 1'b0;
    endtask

    task automatic run_store(input logic [2:0] s, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] ea,
                             input logic [3:0] ebe, input logic [31:0] ew,
                             input string nm);
        start(1'b1, s, a, d);
        step();
        rvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (dreq !== 1'b1 || dwe !== 1'b1 || daddr !== ea) begin
            fails++;
            $display("FAIL %s_c1 got req=%b we=%b addr=%h exp 1/1/%h", nm, dreq, dwe, daddr, ea);
        end
        checks++;
        if (dbe !== ebe || dwdata !== ew) begin
            fails++;
            $display("FAIL %s_lane got be=%b wdata=%h exp be=%b wdata=%h", nm, dbe, dwdata, ebe, ew);
        end
        step();
        rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || dreq !== 1'b0) begin
            fails++;
            $display("FAIL %s_done got stall=%b req=%b exp 0/0", nm, stall, dreq);
        end
        step();
        req = 1'b0;
    endtask

    task automatic run_illegal(input logic w, input logic [2:0] s,
                               input logic [31:0] a, input string nm);
        start(w, s, a, 32'h0);
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || dreq !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL %s_c0 got stall=%b req=%b err=%b exp 1/0/0", nm, stall, dreq, err);
        end
        step();
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || stall !== 1'b0 || dreq !== 1'b0) begin
            fails++;
            $display("FAIL %s_c1 got err=%b stall=%b req=%b exp 1/0/0", nm, err, stall, dreq);
        end
        step();
        req = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || dreq !== 1'b0) begin
            fails++;
            $display("FAIL %s_c2 got err=%b req=%b exp 0/0", nm, err, dreq);
        end
        step();
    endtask

    task automatic test_loads();
        run_load(3'b010, 32'h100, 32'hDEADBEEF, 32'h100, 4'b1111, 32'hDEADBEEF, "lw");
        run_load(3'b000, 32'h103, 32'h80FFFFFF, 32'h100, 4'b1000, 32'hFFFFFF80, "lb");
        run_load(3'b100, 32'h103, 32'h80FFFFFF, 32'h100, 4'b1000, 32'h00000080, "lbu");
        run_load(3'b101, 32'h102, 32'h9ABC0000, 32'h100, 4'b1100, 32'h00009ABC, "lhu");
    endtask

    task automatic test_stores();
        run_store(3'b001, 32'h202, 32'h1234ABCD, 32'h200, 4'b1100, 32'hABCD0000, "sh");
        run_store(3'b000, 32'h201, 32'h00000055, 32'h200, 4'b0010, 32'h00005500, "sb");
    endtask

    task automatic test_illegal();
        run_illegal(1'b0, 3'b011, 32'h100, "size011");
        run_illegal(1'b1, 3'b100, 32'h100, "sbu");
    endtask

    task automatic test_misaligned();
`ifdef MIRISCV_LSU_SPLIT_MISALIGNED_EN
        start(1'b0, 3'b010, 32'h101, 32'h0);
        step();
        rvalid = 1'b1; rdata = 32'h44332211;
        @(negedge clk);
        checks++;
        if (daddr !== 32'h100 || dbe !== 4'b1110 || dreq !== 1'b1) begin
            fails++;
            $display("FAIL split_b1 got addr=%h be=%b req=%b exp 100/1110/1", daddr, dbe, dreq);
        end
        step();
        rdata = 32'h88776655;
        @(negedge clk);
        checks++;
        if (daddr !== 32'h104 || dbe !== 4'b0001 || dreq !== 1'b1 || stall !== 1'b1) begin
            fails++;
            $display("FAIL split_b2 got addr=%h be=%b req=%b stall=%b exp 104/0001/1/1",
                     daddr, dbe, dreq, stall);
        end
        step();
        rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (ldata !== 32'h55443322 || stall !== 1'b0) begin
            fails++;
            $display("FAIL split_done got data=%h stall=%b exp 55443322/0", ldata, stall);
        end
        step();
        req = 1'b0;
        run_load(3'b001, 32'h101, 32'h00BEEF00, 32'h100, 4'b0110, 32'hFFFFBEEF, "lh_off1");
`else
        run_illegal(1'b0, 3'b010, 32'h101, "lw_mis");
        run_illegal(1'b0, 3'b001, 32'h103, "lh_mis");
`endif
    endtask

    task automatic test_timeout();
        int hi_n = 0;
        int err_n = 0;
        logic stall_err = 1'b1;
        logic seen = 1'b0;
        start(1'b0, 3'b010, 32'h300, 32'h0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (dreq) hi_n++;
            if (err) begin
                err_n++;
                stall_err = stall;
                seen = 1'b1;
            end
            step();
            if (seen) req = 1'b0;
        end
        checks++;
        if (hi_n !== 4 || err_n !== 1 || stall_err !== 1'b0) begin
            fails++;
            $display("FAIL timeout got req_cycles=%0d err_pulses=%0d stall=%b exp 4/1/0",
                     hi_n, err_n, stall_err);
        end
        start(1'b0, 3'b010, 32'h304, 32'h0);
        repeat (4) step();
        rvalid = 1'b1; rdata = 32'h0BADF00D;
        @(negedge clk);
        checks++;
        if (dreq !== 1'b1) begin
            fails++;
            $display("FAIL tmo_edge_req got req=%b exp 1", dreq);
        end
        step();
        rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || ldata !== 32'h0BADF00D) begin
            fails++;
            $display("FAIL tmo_edge_done got err=%b data=%h exp 0/0badf00d", err, ldata);
        end
        step();
        req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        start(1'b0, 3'b010, 32'h400, 32'h0);
        step();
        @(negedge clk);
        checks++;
        if (dreq !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_pre got req=%b exp 1", dreq);
        end
        #2;
        rst_n = 1'b0; req = 1'b0;
        #1;
        checks++;
        if ({ldata, stall, err, dreq, dwe, dbe, daddr, dwdata} !== '0) begin
            fails++;
            $display("FAIL rst_mid_outputs got req=%b be=%b addr=%h exp all zero",
                     dreq, dbe, daddr);
        end
        step();
        rst_n = 1'b1;
        step();
        run_load(3'b010, 32'h400, 32'h13579BDF, 32'h400, 4'b1111, 32'h13579BDF, "lw_post_rst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_illegal();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/miriscv_lsu_ctrl.md
# miriscv_lsu_ctrl

Parametrised load-store unit controller between the miriscv core pipeline and the data memory port. It converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned bus transactions with byte enables, lane steering and sign extension. It holds the core in stall until the response returns, and flags misaligned, illegal-size or timed-out accesses. Optionally, it splits misaligned accesses into two bus beats.

## Interface
- ADDR_W, 32: byte-address width; data width is fixed at 32.
- TIMEOUT_CYCLES, 16: maximum number of wait cycles for `data_rvalid_i` per beat; 0 disables the timeout.
- clk_i  in  1  single clock, rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- lsu_req_i  in  1  core access request; held stable while `lsu_stall_req_o`=1.
- lsu_we_i  in  1  1 = store, 0 = load.
- lsu_size_i  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- lsu_addr_i  in  ADDR_W  byte address.
- lsu_data_i  in  32  store data, right-aligned.
- lsu_data_o  out  32  load result, extended; valid in DONE.
- lsu_stall_req_o  out  1  core stall.
- lsu_err_o  out  1  one-cycle pulse on a faulted access.
- data_req_o  out  1  bus request; held until `data_rvalid_i`.
- data_we_o  out  1  bus write.
- data_be_o  out  4  byte enables.
- data_addr_o  out  ADDR_W  word-aligned address, with [1:0]=0.
- data_wdata_o  out  32  lane-steered store data.
- data_rdata_i  in  32  read data; valid with `data_rvalid_i`.
- data_rvalid_i  in  1  beat completion for both reads and writes.

## Operation
- States: IDLE, REQ, REQ2, DONE, ERR.
- IDLE:
  - `lsu_req_i`=0: stay in IDLE.
  - Legal access: go to REQ.
  - Illegal access: go to ERR.
- Illegal access is any of:
  - size 011, 110 or 111;
  - a store with size[2]=1;
  - a misaligned access when the split feature is absent.
- Misaligned means H with addr[0]=1, or W with addr[1:0]≠0.
- Lane math, with off = addr[1:0]:
  - wide_be = {4'b0, m} << off, where m = 0001 / 0011 / 1111 for B / H / W.
  - wide_wd = {32'b0, data} << 8·off.
  - Beat 1 uses the low 32 bits; beat 2 uses the high 32 bits at address +4.
- A second beat is needed iff wide_be[7:4]≠0.
- REQ:
  - `data_req_o`=1 with beat-1 signals.
  - On `data_rvalid_i`, capture `data_rdata_i` into lo.
  - Then go to REQ2 if a second beat is needed, else to DONE.
- REQ2:
  - Beat-2 signals (word address+4).
  - On `data_rvalid_i`, capture into hi and go to DONE.
- Load result: ({hi,lo} >> 8·off), truncated to the access size, then sign-extended (B/H) or zero-extended (BU/HU).
- DONE:
  - `lsu_data_o` is valid; stall=0.
  - `lsu_req_i` is ignored this cycle.
  - Next state is IDLE.
- ERR:
  - `lsu_err_o`=1, stall=0, no bus activity.
  - Next state is IDLE.
- Timeout (TIMEOUT_CYCLES>0):
  - A per-beat counter is cleared on beat entry and increments each REQ/REQ2 cycle without rvalid.
  - When it reaches TIMEOUT_CYCLES, `data_req_o` drops and the state goes to ERR.
  - A store beat 1 already completed is not rolled back.
- Stall: `lsu_stall_req_o` = `lsu_req_i` & (state ∉ {DONE, ERR}), combinational.

## Timing
- Reset (asynchronous, any state, mid-beat included):
  - State returns to IDLE and all counters clear.
  - All outputs read 0, including `lsu_data_o`.
  - An outstanding bus beat is abandoned.
- Single-beat latency, with rvalid in the first REQ cycle:
  - Cycle 0 IDLE (stall=1), cycle 1 REQ (stall=1), cycle 2 DONE (stall=0).
  - Each memory wait cycle adds one cycle.
- Split access: minimum latency 4 cycles (IDLE, REQ, REQ2, DONE).
- Illegal access: cycle 0 IDLE (stall=1), cycle 1 ERR (err=1, stall=0).
- Bus outputs are decoded from registered state and latched request fields, with no combinational path from `data_rvalid_i` to `data_req_o`. The address and data fields are latched in IDLE.
- `data_rvalid_i` outside REQ/REQ2 is ignored.
- Timeout and rvalid arriving in the same cycle: rvalid wins.

## Configuration
- MIRISCV_LSU_SPLIT_MISALIGNED_EN defined:
  - Misaligned H/W accesses are legal.
  - Accesses that cross a word boundary use REQ2.
  - H at off=1 is a single beat with be=0110.
- Not defined:
  - REQ2 is unreachable and may be optimised away.
  - Every misaligned access goes to ERR with no bus beat.

## Test plan
- LW at 0x100, memory returns 0xDEADBEEF with rvalid in the first REQ cycle -> `data_addr_o`=0x100, be=1111, `lsu_data_o`=0xDEADBEEF in cycle 2, stall low in cycle 2 only.
- LB at 0x103 with rdata 0x80FFFFFF -> be=1000, `lsu_data_o`=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x202 with data 0x1234ABCD -> be=1100, `data_wdata_o`=0xABCD0000, we=1. SB at 0x201 with data 0x55 -> be=0010, wdata=0x00005500.
- LW at 0x101:
  - Without the macro -> err pulse, no `data_req_o`.
  - With the macro and beats 0x44332211 then 0x88776655 -> addresses 0x100 then 0x104, be 1110 then 0001, `lsu_data_o`=0x55443322.
- TIMEOUT_CYCLES=4, LW with rvalid never asserted -> `data_req_o` high for exactly 4 cycles, then `lsu_err_o` pulses once and stall drops.
- Reset asserted mid-REQ -> all outputs 0 immediately. A new LW after release completes normally.
